// File: rtl/reg_bank_8x16.sv
// Eight-entry register bank with byte-enable write-back and a pending-write scoreboard.
// Optional build macro R0_ZERO_EN turns r0 into a hard-wired zero register.
module reg_bank_8x16 #(
  parameter int unsigned    WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [1:0]       wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             issue_en,
  input  logic [2:0]       issue_dst,
  input  logic             rs_a_vld,
  input  logic             rs_b_vld,
  input  logic [2:0]       rs_a,
  input  logic [2:0]       rs_b,
  output logic [WIDTH-1:0] data0,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] data3,
  output logic [WIDTH-1:0] data4,
  output logic [WIDTH-1:0] data5,
  output logic [WIDTH-1:0] data6,
  output logic [WIDTH-1:0] data7,
  output logic [7:0]       pending,
  output logic             hazard,
  output logic             issue_err
);

  localparam int unsigned HALF = WIDTH / 2;

`ifdef R0_ZERO_EN
  localparam logic [WIDTH-1:0] R0_RESET_VAL = '0;
`else
  localparam logic [WIDTH-1:0] R0_RESET_VAL = RESET_VAL;
`endif

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic [7:0]       pending_q, pending_d;
  logic             issue_err_q, issue_err_d;
  logic             wr_ok, issue_ok;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    regs_d      = regs_q;
    pending_d   = pending_q;
    issue_err_d = 1'b0;
    wr_ok       = wr_en;
    issue_ok    = issue_en;
`ifdef R0_ZERO_EN
    wr_ok       = wr_en && (wr_addr != 3'd0);
    issue_ok    = issue_en && (issue_dst != 3'd0);
`endif

    if (wr_ok) begin
      if (wr_be[1]) regs_d[wr_addr][WIDTH-1:HALF] = wr_data[WIDTH-1:HALF];
      if (wr_be[0]) regs_d[wr_addr][HALF-1:0]     = wr_data[HALF-1:0];
      pending_d[wr_addr] = 1'b0;
    end

    // The set is applied after the clear so a new producer supersedes the retiring one.
    if (issue_ok) begin
      issue_err_d          = pending_q[issue_dst] && !(wr_ok && (wr_addr == issue_dst));
      pending_d[issue_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register array is reset explicitly because software expects RESET_VAL, so it maps to flops, not RAM.
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= (i == 0) ? R0_RESET_VAL : RESET_VAL;
      end
      pending_q   <= '0;
      issue_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      regs_q      <= regs_d;
      pending_q   <= pending_d;
      issue_err_q <= issue_err_d;
    end
  end

  assign data0     = regs_q[0];
  assign data1     = regs_q[1];
  assign data2     = regs_q[2];
  assign data3     = regs_q[3];
  assign data4     = regs_q[4];
  assign data5     = regs_q[5];
  assign data6     = regs_q[6];
  assign data7     = regs_q[7];
  assign pending   = pending_q;
  assign issue_err = issue_err_q;

  // Stall stays up through a same-cycle write-back; it drops once the new data is visible.
  assign hazard = (rs_a_vld && pending_q[rs_a]) || (rs_b_vld && pending_q[rs_b]);

endmodule
